sram_march_bist: RTL

SRAM_MARCH_BIST -- requirements
Module: sram_march_bist

---
 rtl/sram_bist_pkg.sv | 47 ++++
 rtl/sram_bist_cmp.sv | 89 ++++++++
 rtl/sram_march_bist.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/sram_bist_pkg.sv
// sram_bist_pkg
// Shared definitions for the March C- SRAM BIST:
//   - FSM state encoding
//   - march op encoding and the per-element descriptor
//   - the six-element March C- table (direction, op count, ops, polarities)
//   - the checkerboard background pattern (sliced to the data width by users)
package sram_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } march_op_e;

  // pol = 0 means background B, pol = 1 means ~B
  typedef struct packed {
    logic      down;
    logic      two_ops;
    march_op_e op0;
    logic      pol0;
    march_op_e op1;
    logic      pol1;
  } march_elem_t;

  localparam int unsigned NUM_ELEMS = 6;
  localparam logic [2:0]  LAST_ELEM = 3'd5;

  // M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 up(r0)
  localparam march_elem_t MARCH_TBL [NUM_ELEMS] = '{
    '{down: 1'b0, two_ops: 1'b0, op0: OP_WR, pol0: 1'b0, op1: OP_RD, pol1: 1'b0},
    '{down: 1'b0, two_ops: 1'b1, op0: OP_RD, pol0: 1'b0, op1: OP_WR, pol1: 1'b1},
    '{down: 1'b0, two_ops: 1'b1, op0: OP_RD, pol0: 1'b1, op1: OP_WR, pol1: 1'b0},
    '{down: 1'b1, two_ops: 1'b1, op0: OP_RD, pol0: 1'b0, op1: OP_WR, pol1: 1'b1},
    '{down: 1'b1, two_ops: 1'b1, op0: OP_RD, pol0: 1'b1, op1: OP_WR, pol1: 1'b0},
    '{down: 1'b0, two_ops: 1'b0, op0: OP_RD, pol0: 1'b0, op1: OP_RD, pol1: 1'b0}
  };

  // 0x55.. checkerboard; wide enough for any practical word, sliced by the user
  localparam logic [1023:0] CHECKER_PAT = {256{4'h5}};

endpackage

// File: rtl/sram_bist_cmp.sv
// sram_bist_cmp
// Read-data checker for the March BIST. A read issued this cycle has its
// expected word and address registered; the next cycle the SRAM data is
// compared and miscompares are logged.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   clr             clears the results (test start accepted)
//   flush           drops any read in flight and its pending compare (abort)
//   rd_vld          a read is being issued to the SRAM this cycle
//   rd_addr, rd_exp address and expected word of that read
//   dout            SRAM read data, valid the cycle after the read
//   fail            sticky miscompare flag
//   fail_count      saturating miscompare count
//   fail_addr       address of the first miscompare
module sram_bist_cmp
  import sram_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  flush,
  input  logic                  rd_vld,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_exp,
  input  logic [DATA_WIDTH-1:0] dout,
  output logic                  fail,
  output logic [CNT_WIDTH-1:0]  fail_count,
  output logic [ADDR_WIDTH-1:0] fail_addr
);

  logic                  cmp_vld_q, cmp_vld_d;
  logic [DATA_WIDTH-1:0] exp_q, exp_d;
  logic [ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d;
  logic                  fail_q, fail_d;
  logic [CNT_WIDTH-1:0]  fail_count_q, fail_count_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic                  miscmp;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_comb begin
    // stage: read issued -> capture expected word and address
    cmp_vld_d  = rd_vld && !flush;
    exp_d      = rd_exp;
    cmp_addr_d = rd_addr;

    // stage: read data returned -> compare and log
    miscmp       = cmp_vld_q && (dout != exp_q) && !flush;
    fail_d       = fail_q;
    fail_count_d = fail_count_q;
    fail_addr_d  = fail_addr_q;
    if (clr) begin
      fail_d       = 1'b0;
      fail_count_d = '0;
      fail_addr_d  = '0;
    end else if (miscmp) begin
      fail_d       = 1'b1;
      fail_count_d = sat_inc(fail_count_q);
      if (!fail_q) fail_addr_d = cmp_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    exp_q      <= exp_d;
    cmp_addr_q <= cmp_addr_d;
    if (!rst_n) begin
      cmp_vld_q    <= 1'b0;
      fail_q       <= 1'b0;
      fail_count_q <= '0;
      fail_addr_q  <= '0;
    end else begin
      cmp_vld_q    <= cmp_vld_d;
      fail_q       <= fail_d;
      fail_count_q <= fail_count_d;
      fail_addr_q  <= fail_addr_d;
    end
  end

  assign fail       = fail_q;
  assign fail_count = fail_count_q;
  assign fail_addr  = fail_addr_q;

endmodule

// File: rtl/sram_march_bist.sv
// sram_march_bist
// March C- built-in self test for a single-port SRAM with 1-cycle read latency.
// Sequence: M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1);
//           M4 down(r1,w0); M5 up(r0), one SRAM op per RUN cycle.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start, abort, bg_sel  test request, test abort, background select (0: 0/1, 1: 55/AA)
//   busy, done            RUN/DRAIN indicator, one-cycle completion pulse
//   fail, fail_count,     sticky fail, saturating miscompare count,
//   fail_addr             first failing address
//   csb, web, wmask,      SRAM control (active-low), byte mask,
//   addr, din, dout       address, write data, read data
module sram_march_bist
  import sram_bist_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int WMASK_WIDTH = 4,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   bg_sel,
  output logic                   busy,
  output logic                   done,
  output logic                   fail,
  output logic [CNT_WIDTH-1:0]   fail_count,
  output logic [ADDR_WIDTH-1:0]  fail_addr,
  output logic                   csb,
  output logic                   web,
  output logic [WMASK_WIDTH-1:0] wmask,
  output logic [ADDR_WIDTH-1:0]  addr,
  output logic [DATA_WIDTH-1:0]  din,
  input  logic [DATA_WIDTH-1:0]  dout
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  bist_state_e           state_q, state_d;
  logic [2:0]            elem_q, elem_d;
  logic                  opi_q, opi_d;
  logic                  bg_q, bg_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  csb_q, csb_d;
  logic                  web_q, web_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [DATA_WIDTH-1:0] rd_exp_q, rd_exp_d;

  logic                  last_addr, last_op, seq_end;
  logic [2:0]            nx_elem;
  logic                  nx_opi;
  logic [ADDR_WIDTH-1:0] nx_addr;
  logic                  issue;
  logic [2:0]            op_elem;
  logic                  op_opi;
  logic [ADDR_WIDTH-1:0] op_addr;
  logic                  op_wr, op_pol;
  logic [DATA_WIDTH-1:0] bg_word, op_word;

  // Position of the op following the one currently on the SRAM pins.
  always_comb begin
    last_addr = MARCH_TBL[elem_q].down ? (addr_q == '0) : (addr_q == ADDR_MAX);
    last_op   = !MARCH_TBL[elem_q].two_ops || opi_q;
    seq_end   = (elem_q == LAST_ELEM) && last_addr && last_op;
    nx_elem   = elem_q;
    nx_opi    = 1'b0;
    nx_addr   = addr_q;
    if (!last_op) begin
      nx_opi = 1'b1;
    end else if (last_addr) begin
      if (elem_q != LAST_ELEM) begin
        nx_elem = elem_q + 3'd1;
        nx_addr = MARCH_TBL[nx_elem].down ? ADDR_MAX : '0;
      end
    end else if (MARCH_TBL[elem_q].down) begin
      nx_addr = addr_q - ADDR_WIDTH'(1);
    end else begin
      nx_addr = addr_q + ADDR_WIDTH'(1);
    end
  end

  // FSM next state plus the SRAM command registered for the next cycle.
  always_comb begin
    state_d = state_q;
    bg_d    = bg_q;
    issue   = 1'b0;
    op_elem = elem_q;
    op_opi  = opi_q;
    op_addr = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          bg_d    = bg_sel;
          issue   = 1'b1;
          op_elem = '0;
          op_opi  = 1'b0;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (seq_end) begin
          state_d = ST_DRAIN;
        end else begin
          issue   = 1'b1;
          op_elem = nx_elem;
          op_opi  = nx_opi;
          op_addr = nx_addr;
        end
      end
      ST_DRAIN: state_d = abort ? ST_IDLE : ST_DONE;
      default:  state_d = ST_IDLE;
    endcase

    op_wr   = (op_opi ? MARCH_TBL[op_elem].op1 : MARCH_TBL[op_elem].op0) == OP_WR;
    op_pol  = op_opi ? MARCH_TBL[op_elem].pol1 : MARCH_TBL[op_elem].pol0;
    // bg_d so the very first op already uses the background latched with start
    bg_word = bg_d ? CHECKER_PAT[DATA_WIDTH-1:0] : '0;
    op_word = op_pol ? ~bg_word : bg_word;

    elem_d   = op_elem;
    opi_d    = op_opi;
    csb_d    = !issue;
    web_d    = !(issue && op_wr);
    addr_d   = issue ? op_addr : '0;
    din_d    = (issue && op_wr) ? op_word : '0;
    rd_exp_d = op_word;
    busy_d   = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    rd_exp_q <= rd_exp_d;
    if (!rst_n) begin
      state_q <= ST_IDLE;
      elem_q  <= '0;
      opi_q   <= 1'b0;
      bg_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      opi_q   <= opi_d;
      bg_q    <= bg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  // abort is only honoured while a test is in flight
  sram_bist_cmp #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_cmp (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        ((state_q == ST_IDLE) && start),
    .flush      (abort && ((state_q == ST_RUN) || (state_q == ST_DRAIN))),
    .rd_vld     (!csb_q && web_q),
    .rd_addr    (addr_q),
    .rd_exp     (rd_exp_q),
    .dout       (dout),
    .fail       (fail),
    .fail_count (fail_count),
    .fail_addr  (fail_addr)
  );

  assign busy  = busy_q;
  assign done  = done_q;
  assign csb   = csb_q;
  assign web   = web_q;
  assign wmask = '1;
  assign addr  = addr_q;
  assign din   = din_q;

endmodule
